// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)
//   that owns the PC, the instruction register and the retired-instruction count.
// Latency: 4 cycles per non-memory instruction plus fetch waits.
//   Loads and stores add one MEM cycle plus data waits.
// Backpressure: req/ack handshakes. A request is held with a stable address until a
//   single-cycle ack is seen. Acks that arrive outside the owning state are ignored.
// Ports:
//   i_clk, i_reset             clock (rising edge), asynchronous active-low reset
//   o_imem_*, i_imem_*         instruction fetch port
//   o_instr                    registered instruction word, feeds the external decoder
//   i_dec_*, i_imm             decoder results, held stable from DECODE through WB
//   i_rs2, i_alu_y             register-file rs2 data and combinational ALU result
//   o_dmem_*, i_dmem_*         data load/store port
//   o_rf_we, o_wb_data         register-file write strobe and write data
//   o_pc, o_halted, o_trap     architectural PC and stop status
//   o_instret                  retired-instruction counter (wraps)
module pc_sequencer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [XLEN-1:0]   i_imem_rdata,
  output logic [XLEN-1:0]   o_instr,
  input  logic              i_dec_w_en,
  input  logic              i_dec_jmp,
  input  logic              i_dec_branch,
  input  logic              i_dec_load,
  input  logic              i_dec_store,
  input  logic              i_dec_illegal,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [XLEN-1:0]   i_alu_y,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  output logic              o_rf_we,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  output logic              o_trap,
  output logic [CNT_W-1:0]  o_instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_pc;
  logic [XLEN-1:0]     r_instr;
  logic [XLEN-1:0]     r_alu_q;
  logic [XLEN-1:0]     r_rs2_q;
  logic [XLEN-1:0]     r_ld_q;
  logic [CNT_W-1:0]    r_instret;
  logic                r_trap;

  // Next-PC candidates, all modulo 2^ADDR_W.
  logic [ADDR_W-1:0]   w_alu_addr;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [ADDR_W-1:0]   w_jmp_tgt;
  logic [ADDR_W-1:0]   w_br_tgt;
  logic [ADDR_W-1:0]   w_next_pc;
  logic                w_br_taken;
  logic                w_misalign;

  logic                w_imem_req;
  logic                w_dmem_req;
  logic                w_dmem_we;
  logic                w_rf_we;
  logic [XLEN-1:0]     w_wb_data;

  assign w_alu_addr = ADDR_W'(r_alu_q);
  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  // Jump targets always drop bit 0; bit 1 is left in so it can be trapped.
  assign w_jmp_tgt  = {w_alu_addr[ADDR_W-1:1], 1'b0};
  assign w_br_tgt   = r_pc + ADDR_W'(i_imm);
  // The ALU result of a branch is its comparison outcome: non-zero means taken.
  assign w_br_taken = i_dec_branch && (r_alu_q != '0);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (i_dec_jmp) begin
      w_next_pc = w_jmp_tgt;
    end else if (w_br_taken) begin
      w_next_pc = w_br_tgt;
    end
  end

  // Only word-aligned (bit 1 clear) targets may be loaded into the PC.
  assign w_misalign = w_next_pc[1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-state output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_rf_we      = 1'b0;
    w_wb_data    = '0;

    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        w_next_state = i_dec_illegal ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        w_next_state = (i_dec_load || i_dec_store) ? S_MEM : S_WB;
      end

      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = i_dec_store;
        if (i_dmem_ack) begin
          w_next_state = S_WB;
        end
      end

      S_WB: begin
        // The register write happens even when the PC update traps.
        w_rf_we = i_dec_w_en;
        if (i_dec_load) begin
          w_wb_data = r_ld_q;
        end else if (i_dec_jmp) begin
          w_wb_data = XLEN'(w_pc_plus4);
        end else begin
          w_wb_data = r_alu_q;
        end
        w_next_state = w_misalign ? S_HALT : S_FETCH;
      end

      S_HALT: begin
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = S_HALT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_alu_q   <= '0;
      r_rs2_q   <= '0;
      r_ld_q    <= '0;
      r_instret <= '0;
      r_trap    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_imem_ack) begin
            r_instr <= i_imem_rdata;
          end
        end

        S_DECODE: begin
          if (i_dec_illegal) begin
            r_trap <= 1'b1;
          end
        end

        S_EXEC: begin
          r_alu_q <= i_alu_y;
          r_rs2_q <= i_rs2;
        end

        S_MEM: begin
          if (i_dmem_ack && i_dec_load) begin
            r_ld_q <= i_dmem_rdata;
          end
        end

        S_WB: begin
          if (w_misalign) begin
            // PC keeps pointing at the offending instruction.
            r_trap <= 1'b1;
          end else begin
            r_pc      <= w_next_pc;
            r_instret <= r_instret + CNT_W'(1);
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Reset parks the FSM in FETCH, so the fetch request is qualified by the reset
  // pin itself: it is low while reset is held and already high for the first
  // rising edge after release.
  assign o_imem_req   = w_imem_req && i_reset;
  assign o_imem_addr  = r_pc;
  assign o_instr      = r_instr;
  assign o_dmem_req   = w_dmem_req;
  assign o_dmem_we    = w_dmem_we;
  assign o_dmem_addr  = w_alu_addr;
  assign o_dmem_wdata = r_rs2_q;
  assign o_rf_we      = w_rf_we;
  assign o_wb_data    = w_wb_data;
  assign o_pc         = r_pc;
  assign o_halted     = (r_state == S_HALT);
  assign o_trap       = r_trap;
  assign o_instret    = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (XLEN=ADDR_W=32, CNT_W=4).
// Acts as instruction/data memory and decoder; a transaction-level model tracks PC,
// retired count and the expected observable result of each instruction.
module tb_pc_sequencer;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_rdata;
  logic [XLEN-1:0]   instr;
  logic              dec_w_en, dec_jmp, dec_branch, dec_load, dec_store, dec_illegal;
  logic [XLEN-1:0]   imm, rs2, alu_y;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic              rf_we;
  logic [XLEN-1:0]   wb_data;
  logic [ADDR_W-1:0] pc;
  logic              halted, trap;
  logic [CNT_W-1:0]  instret;

  pc_sequencer #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(32'h0), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_reset(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata), .o_instr(instr),
    .i_dec_w_en(dec_w_en), .i_dec_jmp(dec_jmp), .i_dec_branch(dec_branch),
    .i_dec_load(dec_load), .i_dec_store(dec_store), .i_dec_illegal(dec_illegal),
    .i_imm(imm), .i_rs2(rs2), .i_alu_y(alu_y),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_rf_we(rf_we), .o_wb_data(wb_data), .o_pc(pc), .o_halted(halted),
    .o_trap(trap), .o_instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One instruction as seen by memory and decoder.
  typedef struct packed {
    logic [1:0]  fw;       // fetch wait cycles before ack
    logic [1:0]  mw;       // data wait cycles before ack
    logic        w_en, jmp, br, ld, st, ill;
    logic        abort;    // pulse reset during the first MEM cycle
    logic [31:0] imm, rs2, alu, ldv, code;
  } op_t;

  // Reference state.
  logic [31:0]      m_pc;
  logic [CNT_W-1:0] m_ret;

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instret", instret, 4'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    m_pc  = 32'h0;
    m_ret = '0;
  endtask

  task automatic halt_watch();
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_halted", halted, 1'b1);
      chk("halt_imem_req", imem_req, 1'b0);
      chk("halt_dmem_req", dmem_req, 1'b0);
      chk("halt_rf_we", rf_we, 1'b0);
      chk("halt_pc", pc, m_pc);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  // Called with the DUT waiting in its fetch cycle; returns in the next fetch cycle
  // (or after a halt / reset).
  task automatic run_op(input op_t t);
    logic [31:0] exp_wb, exp_nxt;
    logic        exp_trap;
    dec_w_en = t.w_en; dec_jmp = t.jmp; dec_branch = t.br;
    dec_load = t.ld;   dec_store = t.st; dec_illegal = t.ill;
    imm = t.imm; rs2 = t.rs2; alu_y = t.alu;

    // Instruction fetch, with stray data acks that must be ignored.
    for (int k = 0; k <= int'(t.fw); k++) begin
      chk("f_imem_req", imem_req, 1'b1);
      chk("f_imem_addr", imem_addr, m_pc);
      chk("f_dmem_req", dmem_req, 1'b0);
      imem_ack   = (k == int'(t.fw));
      imem_rdata = (k == int'(t.fw)) ? t.code : $urandom;
      dmem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    // Decode cycle; a stray fetch ack here must not disturb the instruction.
    dmem_ack = 1'b0;
    chk("d_instr", instr, t.code);
    chk("d_imem_req", imem_req, 1'b0);
    chk("d_rf_we", rf_we, 1'b0);
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;

    if (t.ill) begin
      chk("ill_halted", halted, 1'b1);
      chk("ill_trap", trap, 1'b1);
      chk("ill_imem_req", imem_req, 1'b0);
      chk("ill_instret", instret, m_ret);
      halt_watch();
      return;
    end

    // Execute cycle.
    chk("e_instr_hold", instr, t.code);
    chk("e_dmem_req", dmem_req, 1'b0);
    chk("e_rf_we", rf_we, 1'b0);
    @(negedge clk);

    if (t.ld || t.st) begin
      if (t.abort) begin
        chk("ab_dmem_req_before", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ab_dmem_req_drop", dmem_req, 1'b0);
        do_reset();
        chk("ab_refetch_req", imem_req, 1'b1);
        chk("ab_refetch_addr", imem_addr, 32'h0);
        return;
      end
      for (int k = 0; k <= int'(t.mw); k++) begin
        chk("m_dmem_req", dmem_req, 1'b1);
        chk("m_dmem_addr", dmem_addr, t.alu);
        chk("m_dmem_we", dmem_we, t.st);
        if (t.st) chk("m_dmem_wdata", dmem_wdata, t.rs2);
        chk("m_imem_req", imem_req, 1'b0);
        dmem_ack   = (k == int'(t.mw));
        dmem_rdata = (k == int'(t.mw)) ? t.ldv : $urandom;
        imem_ack   = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      imem_ack = 1'b0;
    end

    // Write-back cycle: expectations straight from the instruction semantics.
    if (t.ld)       exp_wb = t.ldv;
    else if (t.jmp) exp_wb = m_pc + 32'd4;
    else            exp_wb = t.alu;
    if (t.jmp)                      exp_nxt = t.alu & 32'hFFFF_FFFE;
    else if (t.br && t.alu != 0)    exp_nxt = m_pc + t.imm;
    else                            exp_nxt = m_pc + 32'd4;
    exp_trap = exp_nxt[1];

    chk("wb_rf_we", rf_we, t.w_en);
    chk("wb_data", wb_data, exp_wb);
    chk("wb_dmem_req", dmem_req, 1'b0);
    chk("wb_imem_req", imem_req, 1'b0);
    @(negedge clk);

    if (!exp_trap) begin
      m_pc  = exp_nxt;
      m_ret = m_ret + 1'b1;
    end
    chk("n_pc", pc, m_pc);
    chk("n_instret", instret, m_ret);
    chk("n_trap", trap, exp_trap);
    chk("n_halted", halted, exp_trap);
    chk("n_rf_we", rf_we, 1'b0);
    if (exp_trap) halt_watch();
  endtask

  initial begin
    op_t t;
    int  kind;
    rst_n = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    dec_w_en = 1'b0; dec_jmp = 1'b0; dec_branch = 1'b0;
    dec_load = 1'b0; dec_store = 1'b0; dec_illegal = 1'b0;
    imm = '0; rs2 = '0; alu_y = '0;
    #3;
    do_reset();

    // ALU op, fetch acked after 3 waits: 7 cycles total.
    t = '0; t.fw = 2'd3; t.w_en = 1'b1; t.alu = 32'h1234_5678; t.code = 32'h0000_0033;
    run_op(t);
    // Load from 0x100 after 2 data waits.
    t = '0; t.ld = 1'b1; t.w_en = 1'b1; t.alu = 32'h100; t.mw = 2'd2;
    t.ldv = 32'hDEAD_BEEF; t.code = 32'h0001_0003;
    run_op(t);
    // Store.
    t = '0; t.st = 1'b1; t.alu = 32'h200; t.rs2 = 32'hCAFE_F00D; t.mw = 2'd1;
    t.code = 32'h0002_0023;
    run_op(t);
    // Jump to 0x20, taken branch back by 8.
    t = '0; t.jmp = 1'b1; t.w_en = 1'b1; t.alu = 32'h20; t.code = 32'h0000_006F;
    run_op(t);
    t = '0; t.br = 1'b1; t.imm = 32'hFFFF_FFF8; t.alu = 32'h1; t.code = 32'h0000_0063;
    run_op(t);
    // Jump to 0x21 (bit 0 dropped -> 0x20), not-taken branch.
    t = '0; t.jmp = 1'b1; t.w_en = 1'b1; t.alu = 32'h21; t.code = 32'h0000_00EF;
    run_op(t);
    t = '0; t.br = 1'b1; t.imm = 32'hFFFF_FFF8; t.alu = 32'h0; t.code = 32'h0000_0163;
    run_op(t);
    // Jump to 0x40, then JAL with target 0x81 -> 0x80, link 0x44.
    t = '0; t.jmp = 1'b1; t.w_en = 1'b1; t.alu = 32'h40; t.code = 32'h0000_016F;
    run_op(t);
    t = '0; t.jmp = 1'b1; t.w_en = 1'b1; t.alu = 32'h81; t.code = 32'h0000_01EF;
    run_op(t);
    // PC wrap at the top of the address space.
    t = '0; t.jmp = 1'b1; t.alu = 32'hFFFF_FFFC; t.code = 32'h0000_026F;
    run_op(t);
    t = '0; t.w_en = 1'b1; t.alu = 32'h5; t.code = 32'h0000_0133;
    run_op(t);

    // Random non-trapping mix.
    for (int i = 0; i < 40; i++) begin
      t = '0;
      kind   = $urandom_range(0, 4);
      t.fw   = 2'($urandom_range(0, 3));
      t.mw   = 2'($urandom_range(0, 3));
      t.code = $urandom;
      t.rs2  = $urandom;
      t.ldv  = $urandom;
      t.imm  = $urandom & 32'hFFFF_FFFC;
      t.alu  = $urandom;
      t.w_en = 1'($urandom_range(0, 1));
      case (kind)
        1: t.ld = 1'b1;
        2: begin t.st = 1'b1; t.w_en = 1'b0; end
        3: begin t.br = 1'b1; if ($urandom_range(0, 1) == 0) t.alu = 32'h0; end
        4: begin t.jmp = 1'b1; t.alu = t.alu & 32'hFFFF_FFFD; end
        default: ;
      endcase
      run_op(t);
    end

    // Misaligned JAL target at 0x40: write-back happens, then trap.
    t = '0; t.jmp = 1'b1; t.w_en = 1'b1; t.alu = 32'h40; t.code = 32'h0000_036F;
    run_op(t);
    t = '0; t.jmp = 1'b1; t.w_en = 1'b1; t.alu = 32'h82; t.code = 32'h0000_03EF;
    run_op(t);

    // Reset pulse in the middle of a data access, then normal restart.
    do_reset();
    t = '0; t.ld = 1'b1; t.w_en = 1'b1; t.alu = 32'h300; t.mw = 2'd2; t.abort = 1'b1;
    t.code = 32'h0003_0003;
    run_op(t);
    t = '0; t.w_en = 1'b1; t.alu = 32'h77; t.fw = 2'd1; t.code = 32'h0000_0233;
    run_op(t);

    // Illegal instruction halts with trap.
    t = '0; t.ill = 1'b1; t.code = 32'hFFFF_FFFF;
    run_op(t);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
